cache_calc_nway: RTL and testbench
==================================

CACHE_CALC_NWAY -- requirements
Module: cache_calc_nway

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- WAYS, 4, associativity; power of 2, range 2..8.
- SETS, 4, number of sets; power of 2, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, at least 2.
- ADDR_W, 30, word-address width.
- MA_W, derived, log2(WAYS*SETS*LINE_WORDS), data-RAM address width.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- i_clk, in, 1, the single clock.
- i_reset, in, 1, asynchronous active-high reset.
- i_srst, in, 1, synchronous invalidate-all.
- i_en, in, 1, lookup request.
- i_addr, in, ADDR_W, word address of the lookup.
- i_wr_ready, in, 1, one fill word accepted this cycle.
- o_busy, out, 1, high while a lookup result or a fill is pending.
- o_hit, out, 1, one-cycle hit pulse.
- o_miss, out, 1, high for the whole fill.
- o_fill_done, out, 1, one-cycle pulse when the line is installed.
- o_mem_addr_cache, out, MA_W, data-RAM address of the hit word.
- o_mem_addr_load, out, MA_W, data-RAM address of the current fill word.

Function
REQ-003 Address split SHALL be: offset = i_addr[log2(LINE_WORDS)-1:0]; set = the next log2(SETS) bits; tag = the remaining upper bits.
REQ-004 Data-RAM address SHALL be {way, set, offset}, with way in the MSBs.
REQ-005 Storage SHALL be flops: per set and way, one valid bit and one tag; per set, WAYS-1 tree-PLRU bits.
REQ-006 The FSM SHALL have states IDLE, LOOKUP and FILL.
REQ-007 In IDLE, i_en=1 SHALL register i_addr and move to LOOKUP; o_busy SHALL be high from the next cycle.
REQ-008 LOOKUP SHALL last one cycle. On a hit (valid and tag match), the block SHALL pulse o_hit, drive o_mem_addr_cache={hit way, set, offset}, update PLRU for the hit way and return to IDLE.
REQ-009 On a miss in LOOKUP, the victim SHALL be the lowest-numbered invalid way, or the PLRU victim if all ways are valid. The block SHALL then assert o_miss, set o_mem_addr_load={victim, set, 0} and enter FILL.
REQ-010 In FILL, each i_wr_ready SHALL increment the word counter and o_mem_addr_load offset. Offset wraps modulo LINE_WORDS, starting at 0; the block does no critical-word-first ordering.
REQ-011 On the LINE_WORDS-th i_wr_ready, the block SHALL write tag and valid, mark the victim MRU in PLRU, pulse o_fill_done, deassert o_miss and o_busy on the next cycle, and return to IDLE.
REQ-012 PLRU SHALL use node 0 as the root, with children of node n at 2n+1 and 2n+2. A node bit of 1 means the LRU side is the upper half. An access SHALL set every node on its path to point away from the accessed way. The victim SHALL be found by following the node bits.
REQ-013 i_en SHALL be ignored in LOOKUP and FILL; i_wr_ready SHALL be ignored outside FILL.
REQ-014 i_srst SHALL take precedence over all other inputs in the same cycle. It SHALL clear all valid and PLRU bits, abort any fill without writing its tag, and force IDLE with o_busy=0 on the next cycle.
REQ-015 Tags SHALL NOT be cleared on invalidate; valid bits alone gate hits.

Reset
REQ-016 While i_reset is high, asynchronously: state=IDLE, all valid/PLRU bits=0, word counter=0, o_busy=o_hit=o_miss=o_fill_done=0, o_mem_addr_cache=o_mem_addr_load=0. Deassertion mid-fill SHALL leave no partially valid line.

Structure
REQ-017 Shared package cache_pkg SHALL hold the FSM state enum and the log2/width-derivation constants.
REQ-018 Sub-module cache_plru_tree (combinational: PLRU bits + access way -> next bits; PLRU bits -> victim) SHALL be instantiated once.

Verification (WAYS=4, SETS=4, LINE_WORDS=4)
REQ-019 Reset, lookup 0x10 -> o_miss, load addrs 0,1,2,3, fill_done after 4th ack; then lookup 0x12 -> o_hit, o_mem_addr_cache=2.
REQ-020 Fill 0x10,0x20,0x30,0x40 (ways 0-3, set 0), hit 0x10, lookup 0x50 -> miss, victim way 2, load addrs 32..35.
REQ-021 Lookup 0x14 after REQ-019 -> miss in set 1, victim way 0, first load addr 4; set 0 contents unaffected.
REQ-022 i_srst after 2 fill acks -> o_busy=0 next cycle; lookup 0x10 -> miss, load addr 0.
REQ-023 i_reset asserted mid-fill -> all outputs 0 immediately; lookup 0x10 after release -> miss.
REQ-024 i_en pulsed during FILL and i_wr_ready pulsed in IDLE -> no state, address or PLRU change.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the N-way set-associative lookup/fill controller.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FILL   = 2'd2
  } state_t;

  // Ceiling log2; elaboration-time only, used to derive field widths.
  function automatic int log2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_WAYS       = 4;
  localparam int DEF_SETS       = 4;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_ADDR_W     = 30;
  localparam int DEF_MA_W       = log2_f(DEF_WAYS * DEF_SETS * DEF_LINE_WORDS);

endpackage

// File: rtl/cache_calc_nway_if.sv
// Lookup request / fill handshake bundle between a requester and cache_calc_nway.
// Handshake: en is a request taken only while busy is low (ignored otherwise);
// wr_ready accepts exactly one fill word per high cycle and only matters while miss is high.
interface cache_calc_nway_if #(
  parameter int ADDR_W = 30,
  parameter int MA_W   = 6
);
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic              wr_ready;
  logic              busy;
  logic              hit;
  logic              miss;
  logic              fill_done;
  logic [MA_W-1:0]   mem_addr_cache;
  logic [MA_W-1:0]   mem_addr_load;

  modport master (
    output en, addr, wr_ready,
    input  busy, hit, miss, fill_done, mem_addr_cache, mem_addr_load
  );

  modport slave (
    input  en, addr, wr_ready,
    output busy, hit, miss, fill_done, mem_addr_cache, mem_addr_load
  );
endinterface

// File: rtl/cache_plru_tree.sv
// Tree pseudo-LRU: next node bits after touching a way, and the victim the bits point at.
// Node n has children 2n+1 (lower half) and 2n+2 (upper half); a 1 marks the upper half as LRU.
module cache_plru_tree
  import cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int WAY_W = log2_f(WAYS)
) (
  input  logic [WAYS-2:0]  i_bits,
  input  logic [WAY_W-1:0] i_access_way,
  output logic [WAYS-2:0]  o_next_bits,
  output logic [WAY_W-1:0] o_victim
);

  always_comb begin
    int vnode;
    int anode;
    o_victim    = '0;
    o_next_bits = i_bits;
    vnode       = 0;
    anode       = 0;
    // Way index bits are consumed MSB first, one tree level per bit.
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      o_victim[WAY_W-1-lvl] = i_bits[vnode];
      vnode = 2 * vnode + 1 + int'(i_bits[vnode]);
    end
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      o_next_bits[anode] = ~i_access_way[WAY_W-1-lvl];
      anode = 2 * anode + 1 + int'(i_access_way[WAY_W-1-lvl]);
    end
  end

endmodule

// File: rtl/cache_calc_nway.sv
// Set-associative tag/valid/PLRU controller: one-cycle lookup, then a line fill
// paced by i_wr_ready, producing data-RAM addresses laid out as {way, set, offset}.
module cache_calc_nway
  import cache_pkg::*;
#(
  parameter int WAYS       = DEF_WAYS,
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int MA_W       = log2_f(WAYS * SETS * LINE_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_srst,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wr_ready,
  output logic              o_busy,
  output logic              o_hit,
  output logic              o_miss,
  output logic              o_fill_done,
  output logic [MA_W-1:0]   o_mem_addr_cache,
  output logic [MA_W-1:0]   o_mem_addr_load
);

  localparam int WAY_W = log2_f(WAYS);
  localparam int SET_W = log2_f(SETS);
  localparam int OFF_W = log2_f(LINE_WORDS);
  localparam int TAG_W = ADDR_W - SET_W - OFF_W;

  state_t                       state_q, state_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [WAY_W-1:0]             victim_q, victim_d;
  logic [OFF_W-1:0]             cnt_q, cnt_d;
  logic [MA_W-1:0]              load_addr_q, load_addr_d;
  logic [SETS-1:0][WAYS-1:0]    valid_q, valid_d;
  logic [SETS-1:0][WAYS-2:0]    plru_q, plru_d;
  logic [TAG_W-1:0]             tag_q [SETS][WAYS];

  logic [SET_W-1:0]             set_l;
  logic [TAG_W-1:0]             tag_l;
  logic [OFF_W-1:0]             off_l;
  logic [OFF_W-1:0]             cnt_inc;
  logic                         hit_any;
  logic [WAY_W-1:0]             hit_way;
  logic                         inv_any;
  logic [WAY_W-1:0]             inv_way;
  logic [WAY_W-1:0]             plru_access;
  logic [WAYS-2:0]              plru_next;
  logic [WAY_W-1:0]             plru_victim;
  logic [WAY_W-1:0]             miss_victim;
  logic                         tag_we;

  // Every field of the access comes from the registered address, so a single
  // PLRU tree serves both the hit update and the fill update.
  assign off_l   = addr_q[OFF_W-1:0];
  assign set_l   = addr_q[OFF_W +: SET_W];
  assign tag_l   = addr_q[OFF_W+SET_W +: TAG_W];
  assign cnt_inc = cnt_q + OFF_W'(1);

  // Descending scan leaves the lowest-numbered matching way in each result.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[set_l][w] && (tag_q[set_l][w] == tag_l)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[set_l][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign plru_access = (state_q == ST_LOOKUP) ? hit_way : victim_q;
  assign miss_victim = inv_any ? inv_way : plru_victim;

  cache_plru_tree #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_plru (
    .i_bits       (plru_q[set_l]),
    .i_access_way (plru_access),
    .o_next_bits  (plru_next),
    .o_victim     (plru_victim)
  );

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    victim_d         = victim_q;
    cnt_d            = cnt_q;
    load_addr_d      = load_addr_q;
    valid_d          = valid_q;
    plru_d           = plru_q;
    tag_we           = 1'b0;
    o_hit            = 1'b0;
    o_fill_done      = 1'b0;
    o_mem_addr_cache = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          addr_d  = i_addr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit_any) begin
          o_hit            = 1'b1;
          o_mem_addr_cache = {hit_way, set_l, off_l};
          plru_d[set_l]    = plru_next;
          state_d          = ST_IDLE;
        end else begin
          victim_d    = miss_victim;
          cnt_d       = '0;
          load_addr_d = {miss_victim, set_l, OFF_W'(0)};
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        if (i_wr_ready) begin
          cnt_d       = cnt_inc;
          load_addr_d = {victim_q, set_l, cnt_inc};
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            tag_we                   = 1'b1;
            valid_d[set_l][victim_q] = 1'b1;
            plru_d[set_l]            = plru_next;
            o_fill_done              = 1'b1;
            state_d                  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Invalidate-all wins over everything else in the same cycle, including a final fill ack.
    if (i_srst) begin
      state_d          = ST_IDLE;
      valid_d          = '0;
      plru_d           = '0;
      cnt_d            = '0;
      load_addr_d      = '0;
      tag_we           = 1'b0;
      o_hit            = 1'b0;
      o_fill_done      = 1'b0;
      o_mem_addr_cache = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      victim_q    <= '0;
      cnt_q       <= '0;
      load_addr_q <= '0;
      valid_q     <= '0;
      plru_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      victim_q    <= victim_d;
      cnt_q       <= cnt_d;
      load_addr_q <= load_addr_d;
      valid_q     <= valid_d;
      plru_q      <= plru_d;
    end
  end

  // Tags need no reset: a line only becomes visible once its valid bit is written alongside it.
  always_ff @(posedge i_clk) begin
    if (tag_we) tag_q[set_l][victim_q] <= tag_l;
  end

  assign o_busy          = (state_q != ST_IDLE);
  assign o_miss          = (state_q == ST_FILL);
  assign o_mem_addr_load = load_addr_q;

endmodule

// File: tb/tb_cache_calc_nway.sv
// Directed bench for cache_calc_nway (4 ways, 4 sets, 4-word lines) with a queue
// of expected lookup results and fill addresses, checked as the DUT produces them.
module tb_cache_calc_nway;

  localparam int ADDR_W = 30;
  localparam int MA_W   = 6;
  localparam int EW     = MA_W + 1;

  logic i_clk;
  logic i_reset;
  logic i_srst;

  int n_checks;
  int n_pass;

  logic [EW-1:0] exp_q[$];

  cache_calc_nway_if #(.ADDR_W(ADDR_W), .MA_W(MA_W)) bus ();

  cache_calc_nway #(
    .WAYS       (4),
    .SETS       (4),
    .LINE_WORDS (4),
    .ADDR_W     (ADDR_W),
    .MA_W       (MA_W)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_srst           (i_srst),
    .i_en             (bus.en),
    .i_addr           (bus.addr),
    .i_wr_ready       (bus.wr_ready),
    .o_busy           (bus.busy),
    .o_hit            (bus.hit),
    .o_miss           (bus.miss),
    .o_fill_done      (bus.fill_done),
    .o_mem_addr_cache (bus.mem_addr_cache),
    .o_mem_addr_load  (bus.mem_addr_load)
  );

  // Clock and reset.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Expected data-RAM address {way, set, offset} tagged with the hit flag.
  function automatic logic [EW-1:0] ev(input bit is_hit, input int way, input int set, input int off);
    int ma;
    ma = way * 16 + set * 4 + off;
    return {is_hit, MA_W'(ma)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pop_check(input string tag, input logic [EW-1:0] obs);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s scoreboard underflow observed=%0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(obs), 32'(e));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_hit"}, 32'(bus.hit), 32'd0);
    check({tag, "_miss"}, 32'(bus.miss), 32'd0);
    check({tag, "_done"}, 32'(bus.fill_done), 32'd0);
    check({tag, "_cache"}, 32'(bus.mem_addr_cache), 32'd0);
    check({tag, "_load"}, 32'(bus.mem_addr_load), 32'd0);
  endtask

  // Driver: one lookup request, then wait (bounded) for the hit pulse or the miss.
  task automatic lookup(input logic [ADDR_W-1:0] a, input logic [EW-1:0] e);
    bit seen;
    seen = 1'b0;
    @(negedge i_clk);
    bus.en   = 1'b1;
    bus.addr = a;
    exp_q.push_back(e);
    @(negedge i_clk);
    bus.en = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      if (c > 0) @(negedge i_clk);
      #1;
      if (c == 0) check("busy_lookup", 32'(bus.busy), 32'd1);
      if (bus.hit) begin
        seen = 1'b1;
        pop_check("hit_addr", {1'b1, bus.mem_addr_cache});
      end else if (bus.miss) begin
        seen = 1'b1;
        pop_check("miss_load", {1'b0, bus.mem_addr_load});
      end
    end
    if (!seen) begin
      n_checks++;
      $error("FAIL lookup_timeout addr=%0h observed=none expected=%0h", a, e);
      void'(exp_q.pop_front());
    end
  endtask

  // Driver: one fill word accepted, after a random number of idle cycles.
  task automatic ack(input int exp_ma, input bit exp_done);
    repeat ($urandom_range(0, 2)) begin
      @(negedge i_clk);
      #1;
      check("miss_hold", 32'(bus.miss), 32'd1);
    end
    @(negedge i_clk);
    bus.wr_ready = 1'b1;
    exp_q.push_back(ev(1'b0, 0, 0, exp_ma));
    #1;
    pop_check("fill_load", {1'b0, bus.mem_addr_load});
    check("fill_done", 32'(bus.fill_done), 32'(exp_done));
    @(posedge i_clk);
    #1;
    bus.wr_ready = 1'b0;
  endtask

  task automatic fill_line(input int base);
    for (int k = 0; k < 4; k++) ack(base + k, (k == 3));
    @(negedge i_clk);
    #1;
    check("post_fill_busy", 32'(bus.busy), 32'd0);
    check("post_fill_miss", 32'(bus.miss), 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    i_reset      = 1'b1;
    i_srst       = 1'b0;
    bus.en       = 1'b0;
    bus.addr     = '0;
    bus.wr_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    check_all_zero("reset");
    i_reset = 1'b0;

    // Cold miss then hit on the same line.
    lookup(30'h10, ev(1'b0, 0, 0, 0));
    fill_line(0);
    lookup(30'h12, ev(1'b1, 0, 0, 2));

    // Different set; set 0 must still hit.
    lookup(30'h14, ev(1'b0, 0, 1, 0));
    fill_line(4);
    lookup(30'h11, ev(1'b1, 0, 0, 1));

    // Fill the rest of set 0, touch way 0, PLRU must evict way 2.
    lookup(30'h20, ev(1'b0, 1, 0, 0));
    fill_line(16);
    lookup(30'h30, ev(1'b0, 2, 0, 0));
    fill_line(32);
    lookup(30'h40, ev(1'b0, 3, 0, 0));
    fill_line(48);
    lookup(30'h10, ev(1'b1, 0, 0, 0));
    lookup(30'h50, ev(1'b0, 2, 0, 0));
    ack(32, 1'b0);
    ack(33, 1'b0);

    // A request during the fill must be ignored.
    @(negedge i_clk);
    bus.en   = 1'b1;
    bus.addr = 30'h60;
    @(negedge i_clk);
    bus.en = 1'b0;
    #1;
    check("en_in_fill_miss", 32'(bus.miss), 32'd1);
    check("en_in_fill_load", 32'(bus.mem_addr_load), 32'd34);
    ack(34, 1'b0);
    ack(35, 1'b1);
    @(negedge i_clk);
    #1;
    check("fill50_busy", 32'(bus.busy), 32'd0);

    // A fill ack while idle must be ignored.
    @(negedge i_clk);
    bus.wr_ready = 1'b1;
    @(negedge i_clk);
    bus.wr_ready = 1'b0;
    #1;
    check("ack_idle_busy", 32'(bus.busy), 32'd0);
    check("ack_idle_load", 32'(bus.mem_addr_load), 32'd32);
    check("ack_idle_done", 32'(bus.fill_done), 32'd0);
    lookup(30'h53, ev(1'b1, 2, 0, 3));

    // Set 0 is full; PLRU now points at way 1. Invalidate-all part way through.
    lookup(30'h60, ev(1'b0, 1, 0, 0));
    ack(16, 1'b0);
    ack(17, 1'b0);
    @(negedge i_clk);
    i_srst       = 1'b1;
    bus.wr_ready = 1'b1;
    #1;
    check("srst_done", 32'(bus.fill_done), 32'd0);
    @(posedge i_clk);
    #1;
    i_srst       = 1'b0;
    bus.wr_ready = 1'b0;
    check("srst_busy", 32'(bus.busy), 32'd0);
    check("srst_miss", 32'(bus.miss), 32'd0);
    lookup(30'h10, ev(1'b0, 0, 0, 0));
    fill_line(0);

    // Async reset in the middle of a fill.
    lookup(30'h60, ev(1'b0, 1, 0, 0));
    ack(16, 1'b0);
    ack(17, 1'b0);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check_all_zero("midfill_reset");
    @(negedge i_clk);
    i_reset = 1'b0;
    lookup(30'h10, ev(1'b0, 0, 0, 0));
    fill_line(0);
    lookup(30'h13, ev(1'b1, 0, 0, 3));

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
